// File: rtl/div_pkg.sv
// div_pkg -- shared definitions for the sequential divider.
//   DEFAULT_WIDTH : default operand/result width in bits.
//   div_state_e   : FSM state encoding (IDLE, CALC, FIX, DONE).
//   cnt_width()   : width of the iteration counter for a given WIDTH.
package div_pkg;

  localparam int DEFAULT_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } div_state_e;

  // One extra bit so the counter can hold the value WIDTH itself.
  function automatic int cnt_width(input int width);
    return $clog2(width) + 1;
  endfunction

endpackage

// File: rtl/seq_divider_if.sv
// seq_divider_if -- request/result bundle of the sequential divider.
//   Request  (master -> slave): start, is_signed, dividend, divisor.
//   Result   (slave -> master): busy, done, quotient, remainder, DZ, OF, ZF.
//   Debug    (slave -> master): state, the current FSM state.
//
// Handshake: start is a request pulse that the divider samples only while
// it is idle (busy low and done low); operands are captured on that same
// edge. There is no back-pressure: a start seen in any other state is
// dropped. done is a one-cycle completion pulse; the result fields are
// valid from that cycle and held until the next accepted start completes.
interface seq_divider_if
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) ();

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;
  logic             DZ;
  logic             OF;
  logic             ZF;
  div_state_e       state;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder, DZ, OF, ZF, state
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder, DZ, OF, ZF, state
  );

endinterface

// File: rtl/div_step.sv
// div_step -- one combinational restoring-division iteration.
//   rem_in   : current partial remainder (always < divisor)
//   dvd_bit  : next dividend bit, shifted in at the LSB
//   divisor  : divisor magnitude
//   rem_out  : next partial remainder
//   q_bit    : quotient bit produced by this iteration
module div_step
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] rem_in,
  input  logic             dvd_bit,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] rem_out,
  output logic             q_bit
);

  logic [WIDTH:0] trial;

  // WIDTH+1 bits so the shifted-out remainder MSB is kept; the sign of the
  // difference tells whether the divisor fits.
  always_comb begin
    trial   = {rem_in, dvd_bit} - {1'b0, divisor};
    q_bit   = ~trial[WIDTH];
    rem_out = q_bit ? trial[WIDTH-1:0] : {rem_in[WIDTH-2:0], dvd_bit};
  end

endmodule

// File: rtl/seq_divider.sv
// seq_divider -- multi-cycle signed/unsigned restoring divider.
//   clk   : clock, all state on rising edge
//   rst_n : asynchronous active-low reset
//   bus   : seq_divider_if.slave (request, results, flags, debug state)
// A normal divide takes one accept cycle, WIDTH iteration cycles, one
// sign-fix cycle and then pulses done. Divide-by-zero and signed min/-1
// skip straight to DONE with fixed results.
module seq_divider
  import div_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic          clk,
  input  logic          rst_n,
  seq_divider_if.slave  bus
);

  localparam int CNT_W = cnt_width(WIDTH);
  localparam logic [WIDTH-1:0]  MIN_VAL  = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [WIDTH-1:0] dvd_q;   // dividend magnitude, becomes quotient magnitude
  logic [WIDTH-1:0] dsr_q;   // divisor magnitude
  logic [WIDTH-1:0] rem_q;   // partial remainder
  logic             neg_quo_q, neg_rem_q;

  logic [WIDTH-1:0] quo_res_q, rem_res_q;
  logic             dz_q, of_q, zf_q;

  logic             dsr_zero, ovf_case, dvd_neg, dsr_neg, last_iter;
  logic [WIDTH-1:0] dvd_mag, dsr_mag;
  logic [WIDTH-1:0] rem_next;
  logic             q_bit;
  logic [WIDTH-1:0] quo_fix, rem_fix;

  // Request decode, only meaningful in IDLE.
  always_comb begin
    dsr_zero  = (bus.divisor == '0);
    ovf_case  = bus.is_signed && (bus.dividend == MIN_VAL) && (bus.divisor == '1);
    dvd_neg   = bus.is_signed && bus.dividend[WIDTH-1];
    dsr_neg   = bus.is_signed && bus.divisor[WIDTH-1];
    dvd_mag   = dvd_neg ? (~bus.dividend + 1'b1) : bus.dividend;
    dsr_mag   = dsr_neg ? (~bus.divisor + 1'b1) : bus.divisor;
    last_iter = (cnt_q == LAST_CNT);
    quo_fix   = neg_quo_q ? (~dvd_q + 1'b1) : dvd_q;
    rem_fix   = neg_rem_q ? (~rem_q + 1'b1) : rem_q;
  end

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_in  (rem_q),
    .dvd_bit (dvd_q[WIDTH-1]),
    .divisor (dsr_q),
    .rem_out (rem_next),
    .q_bit   (q_bit)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (bus.start) begin
          if (dsr_zero || ovf_case) state_d = DONE;
          else                      state_d = CALC;
        end
      end
      CALC:    if (last_iter) state_d = FIX;
      FIX:     state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and held results.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      dvd_q     <= '0;
      dsr_q     <= '0;
      rem_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      quo_res_q <= '0;
      rem_res_q <= '0;
      dz_q      <= 1'b0;
      of_q      <= 1'b0;
      zf_q      <= 1'b1;
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            cnt_q     <= '0;
            dvd_q     <= dvd_mag;
            dsr_q     <= dsr_mag;
            rem_q     <= '0;
            neg_quo_q <= dvd_neg ^ dsr_neg;
            neg_rem_q <= dvd_neg;
            if (dsr_zero) begin
              quo_res_q <= '1;
              rem_res_q <= bus.dividend;
              dz_q      <= 1'b1;
              of_q      <= 1'b0;
              zf_q      <= 1'b0;
            end else if (ovf_case) begin
              // min / -1 does not fit; return the dividend unchanged.
              quo_res_q <= bus.dividend;
              rem_res_q <= '0;
              dz_q      <= 1'b0;
              of_q      <= 1'b1;
              zf_q      <= 1'b0;
            end
          end
        end
        CALC: begin
          // Quotient bits shift in behind the consumed dividend bits.
          dvd_q <= {dvd_q[WIDTH-2:0], q_bit};
          rem_q <= rem_next;
          cnt_q <= cnt_q + 1'b1;
        end
        FIX: begin
          quo_res_q <= quo_fix;
          rem_res_q <= rem_fix;
          dz_q      <= 1'b0;
          of_q      <= 1'b0;
          zf_q      <= (quo_fix == '0);
        end
        default: ;
      endcase
    end
  end

  assign bus.busy      = (state_q == CALC) || (state_q == FIX);
  assign bus.done      = (state_q == DONE);
  assign bus.quotient  = quo_res_q;
  assign bus.remainder = rem_res_q;
  assign bus.DZ        = dz_q;
  assign bus.OF        = of_q;
  assign bus.ZF        = zf_q;
  assign bus.state     = state_q;

endmodule

// File: tb/tb_seq_divider.sv
// tb_seq_divider -- directed self-checking bench for seq_divider (WIDTH=32).
// Edge numbering: start is driven just after edge 0 and accepted on edge 1.
module tb_seq_divider;
  import div_pkg::*;

  localparam int W = 32;

  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] exp_r[$];

  seq_divider_if #(.WIDTH(W)) bus ();

  seq_divider #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Driver: start pulse after edge 0, accepted on edge 1; operands are
  // scrambled immediately afterwards to prove they were captured.
  task automatic launch(input logic sgn, input logic [W-1:0] a, input logic [W-1:0] b);
    @(posedge clk); #1;
    bus.start     = 1'b1;
    bus.is_signed = sgn;
    bus.dividend  = a;
    bus.divisor   = b;
    @(posedge clk); #1;
    bus.start     = 1'b0;
    bus.is_signed = ~sgn;
    bus.dividend  = $urandom;
    bus.divisor   = $urandom;
  endtask

  // Bounded wait for done, sampling #1 after each edge; returns edge index.
  task automatic wait_done(input int from, output int edges);
    edges = from;
    while (bus.done !== 1'b1 && edges < 100) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic test_reset;
    int e;
    rst_n         = 1'b0;
    bus.start     = 1'b1;   // held during reset: must not be taken
    bus.is_signed = 1'b0;
    bus.dividend  = 32'd9;
    bus.divisor   = 32'd3;
    repeat (3) @(posedge clk);
    #1;
    n_cmp++;
    if (bus.quotient !== 32'd0 || bus.remainder !== 32'd0 || bus.DZ !== 1'b0 ||
        bus.OF !== 1'b0 || bus.ZF !== 1'b1) begin
      n_err++;
      $display("FAIL reset_results: got q=%h r=%h DZ=%b OF=%b ZF=%b expected q=0 r=0 DZ=0 OF=0 ZF=1",
               bus.quotient, bus.remainder, bus.DZ, bus.OF, bus.ZF);
    end
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.state !== IDLE) begin
      n_err++;
      $display("FAIL reset_ctrl: got busy=%b done=%b state=%0d expected busy=0 done=0 state=0",
               bus.busy, bus.done, bus.state);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    bus.start = 1'b0;
    n_cmp++;
    if (bus.busy !== 1'b1 || bus.state !== CALC) begin
      n_err++;
      $display("FAIL reset_first_accept: got busy=%b state=%0d expected busy=1 state=1",
               bus.busy, bus.state);
    end
    wait_done(1, e);
    n_cmp++;
    if (e !== 34 || bus.quotient !== 32'd3 || bus.remainder !== 32'd0) begin
      n_err++;
      $display("FAIL reset_then_9div3: got edge=%0d q=%h r=%h expected edge=34 q=3 r=0",
               e, bus.quotient, bus.remainder);
    end
  endtask

  task automatic test_unsigned_basic;
    launch(1'b0, 32'd100, 32'd7);
    for (int k = 1; k <= 33; k++) begin
      n_cmp++;
      if (bus.busy !== 1'b1 || bus.done !== 1'b0 || bus.quotient !== 32'd3) begin
        n_err++;
        $display("FAIL busy_window cycle %0d: got busy=%b done=%b q=%h expected busy=1 done=0 q=3",
                 k, bus.busy, bus.done, bus.quotient);
      end
      @(posedge clk); #1;
    end
    n_cmp++;
    if (bus.done !== 1'b1 || bus.busy !== 1'b0 || bus.quotient !== 32'd14 ||
        bus.remainder !== 32'd2 || bus.ZF !== 1'b0 || bus.DZ !== 1'b0 || bus.OF !== 1'b0) begin
      n_err++;
      $display("FAIL u100div7 edge34: got done=%b busy=%b q=%h r=%h ZF=%b DZ=%b OF=%b expected done=1 busy=0 q=e r=2 ZF=0 DZ=0 OF=0",
               bus.done, bus.busy, bus.quotient, bus.remainder, bus.ZF, bus.DZ, bus.OF);
    end
    @(posedge clk); #1;
    n_cmp++;
    if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.quotient !== 32'd14) begin
      n_err++;
      $display("FAIL done_pulse_width: got done=%b busy=%b q=%h expected done=0 busy=0 q=e",
               bus.done, bus.busy, bus.quotient);
    end
  endtask

  task automatic test_signed;
    int e;
    launch(1'b1, 32'hFFFF_FFF9, 32'd2);
    wait_done(1, e);
    n_cmp++;
    if (e !== 34 || bus.quotient !== 32'hFFFF_FFFD || bus.remainder !== 32'hFFFF_FFFF || bus.OF !== 1'b0) begin
      n_err++;
      $display("FAIL s_m7div2: got edge=%0d q=%h r=%h OF=%b expected edge=34 q=fffffffd r=ffffffff OF=0",
               e, bus.quotient, bus.remainder, bus.OF);
    end
    launch(1'b0, 32'hFFFF_FFF9, 32'd2);
    wait_done(1, e);
    n_cmp++;
    if (e !== 34 || bus.quotient !== 32'h7FFF_FFFC || bus.remainder !== 32'd1) begin
      n_err++;
      $display("FAIL u_fff9div2: got edge=%0d q=%h r=%h expected edge=34 q=7ffffffc r=1",
               e, bus.quotient, bus.remainder);
    end
    launch(1'b1, 32'd7, 32'hFFFF_FFFE);
    wait_done(1, e);
    n_cmp++;
    if (bus.quotient !== 32'hFFFF_FFFD || bus.remainder !== 32'd1) begin
      n_err++;
      $display("FAIL s_7divm2: got q=%h r=%h expected q=fffffffd r=1", bus.quotient, bus.remainder);
    end
    launch(1'b1, 32'hFFFF_FFF8, 32'hFFFF_FFFD);
    wait_done(1, e);
    n_cmp++;
    if (bus.quotient !== 32'd2 || bus.remainder !== 32'hFFFF_FFFE || bus.ZF !== 1'b0) begin
      n_err++;
      $display("FAIL s_m8divm3: got q=%h r=%h ZF=%b expected q=2 r=fffffffe ZF=0",
               bus.quotient, bus.remainder, bus.ZF);
    end
  endtask

  task automatic test_div_zero;
    int e;
    launch(1'b0, 32'd5, 32'd0);
    wait_done(1, e);
    n_cmp++;
    if (e !== 1 || bus.quotient !== 32'hFFFF_FFFF || bus.remainder !== 32'd5 ||
        bus.DZ !== 1'b1 || bus.OF !== 1'b0 || bus.ZF !== 1'b0) begin
      n_err++;
      $display("FAIL dz_5div0: got edge=%0d q=%h r=%h DZ=%b OF=%b ZF=%b expected edge=1 q=ffffffff r=5 DZ=1 OF=0 ZF=0",
               e, bus.quotient, bus.remainder, bus.DZ, bus.OF, bus.ZF);
    end
    launch(1'b1, 32'hFFFF_FFFB, 32'd0);
    wait_done(1, e);
    n_cmp++;
    if (e !== 1 || bus.quotient !== 32'hFFFF_FFFF || bus.remainder !== 32'hFFFF_FFFB || bus.DZ !== 1'b1) begin
      n_err++;
      $display("FAIL dz_signed_m5div0: got edge=%0d q=%h r=%h DZ=%b expected edge=1 q=ffffffff r=fffffffb DZ=1",
               e, bus.quotient, bus.remainder, bus.DZ);
    end
  endtask

  task automatic test_overflow;
    int e;
    launch(1'b1, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1, e);
    n_cmp++;
    if (e !== 1 || bus.quotient !== 32'h8000_0000 || bus.remainder !== 32'd0 ||
        bus.OF !== 1'b1 || bus.DZ !== 1'b0) begin
      n_err++;
      $display("FAIL of_signed_min: got edge=%0d q=%h r=%h OF=%b DZ=%b expected edge=1 q=80000000 r=0 OF=1 DZ=0",
               e, bus.quotient, bus.remainder, bus.OF, bus.DZ);
    end
    launch(1'b0, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done(1, e);
    n_cmp++;
    if (e !== 34 || bus.quotient !== 32'd0 || bus.remainder !== 32'h8000_0000 ||
        bus.ZF !== 1'b1 || bus.OF !== 1'b0 || bus.DZ !== 1'b0) begin
      n_err++;
      $display("FAIL of_unsigned_min: got edge=%0d q=%h r=%h ZF=%b OF=%b DZ=%b expected edge=34 q=0 r=80000000 ZF=1 OF=0 DZ=0",
               e, bus.quotient, bus.remainder, bus.ZF, bus.OF, bus.DZ);
    end
  endtask

  task automatic test_ignore_start;
    int e;
    int busy_seen;
    launch(1'b0, 32'd1000, 32'd10);
    repeat (9) @(posedge clk);
    #1;   // cycle 10 of the operation
    bus.start     = 1'b1;
    bus.is_signed = 1'b0;
    bus.dividend  = 32'd50;
    bus.divisor   = 32'd0;
    @(posedge clk); #1;
    bus.start = 1'b0;
    wait_done(11, e);
    n_cmp++;
    if (e !== 34 || bus.quotient !== 32'd100 || bus.remainder !== 32'd0 || bus.DZ !== 1'b0) begin
      n_err++;
      $display("FAIL ignore_start_result: got edge=%0d q=%h r=%h DZ=%b expected edge=34 q=64 r=0 DZ=0",
               e, bus.quotient, bus.remainder, bus.DZ);
    end
    busy_seen = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.busy === 1'b1 || bus.done === 1'b1) busy_seen++;
    end
    n_cmp++;
    if (busy_seen !== 0 || bus.quotient !== 32'd100) begin
      n_err++;
      $display("FAIL ignore_start_no_restart: got active_cycles=%0d q=%h expected active_cycles=0 q=64",
               busy_seen, bus.quotient);
    end
  endtask

  task automatic test_reset_mid_calc;
    int e;
    launch(1'b0, 32'd100, 32'd7);
    repeat (11) @(posedge clk);
    #1;   // cycle 12, still iterating
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.state !== IDLE || bus.quotient !== 32'd0 ||
        bus.remainder !== 32'd0 || bus.DZ !== 1'b0 || bus.OF !== 1'b0 || bus.ZF !== 1'b1) begin
      n_err++;
      $display("FAIL reset_mid_calc: got busy=%b done=%b state=%0d q=%h r=%h DZ=%b OF=%b ZF=%b expected 0 0 0 0 0 0 0 1",
               bus.busy, bus.done, bus.state, bus.quotient, bus.remainder, bus.DZ, bus.OF, bus.ZF);
    end
    @(negedge clk);
    rst_n = 1'b1;
    launch(1'b0, 32'd9, 32'd3);
    wait_done(1, e);
    n_cmp++;
    if (e !== 34 || bus.quotient !== 32'd3 || bus.remainder !== 32'd0 || bus.ZF !== 1'b0) begin
      n_err++;
      $display("FAIL after_reset_9div3: got edge=%0d q=%h r=%h ZF=%b expected edge=34 q=3 r=0 ZF=0",
               e, bus.quotient, bus.remainder, bus.ZF);
    end
  endtask

  task automatic test_back_to_back;
    logic [W-1:0] a_v[5] = '{32'd1000, 32'hFFFF_FF9C, 32'hFFFF_FFFF, 32'd0, 32'd7};
    logic [W-1:0] b_v[5] = '{32'd33, 32'd7, 32'd1, 32'd5, 32'd9};
    logic         s_v[5] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
    logic [W-1:0] q_exp, r_exp;
    int e;
    exp_q.push_back(32'd30);        exp_r.push_back(32'd10);
    exp_q.push_back(32'hFFFF_FFF2); exp_r.push_back(32'hFFFF_FFFE);
    exp_q.push_back(32'hFFFF_FFFF); exp_r.push_back(32'd0);
    exp_q.push_back(32'd0);         exp_r.push_back(32'd0);
    exp_q.push_back(32'd0);         exp_r.push_back(32'd7);
    for (int i = 0; i < 5; i++) begin
      // Called right after done: the start lands in the following IDLE cycle.
      launch(s_v[i], a_v[i], b_v[i]);
      wait_done(1, e);
      q_exp = exp_q.pop_front();
      r_exp = exp_r.pop_front();
      n_cmp++;
      if (e !== 34 || bus.quotient !== q_exp || bus.remainder !== r_exp || bus.ZF !== (q_exp == '0)) begin
        n_err++;
        $display("FAIL back_to_back op%0d: got edge=%0d q=%h r=%h ZF=%b expected edge=34 q=%h r=%h ZF=%b",
                 i, e, bus.quotient, bus.remainder, bus.ZF, q_exp, r_exp, (q_exp == '0));
      end
    end
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    test_reset();
    test_unsigned_basic();
    test_signed();
    test_div_zero();
    test_overflow();
    test_ignore_start();
    test_reset_mid_calc();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
